alu_arbiter: RTL and testbench

Shares the single 16-bit combinational ALU between two requesters, e.g. the instruction-execute path and an address/branch unit. Each requester uses a valid/ready request channel and a valid/ready response channel. Operands are registered before they are driven onto the ALU, and ALU outputs are registered into a response holding register. Arbitration is round-robin with one operation in flight at a time.

---
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready
// requesters. Round-robin grant, one operation in flight, operands and
// results registered around the ALU.
module alu_arbiter #(
    parameter int WIDTH  = 16,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CODE_W-1:0] req0_code,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CODE_W-1:0] req1_code,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_carry,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_carry,
    output logic              rsp1_zero,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CODE_W-1:0] alu_code,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              busy,
    output logic              grant_id
);

    // state | meaning
    // IDLE  | waiting for a request; grant is live
    // EXEC  | captured operands drive the ALU for one cycle
    // RESP  | result held until the owning port accepts it
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_served_q, last_served_d;
    logic                grant_id_q, grant_id_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [WIDTH-1:0]    res_q, res_d;
    logic                carry_q, carry_d, zero_q, zero_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;

    logic                grant;
    logic                grant_valid;
    logic                owner_rsp_ready;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        grant           = req1_valid && (!req0_valid || !last_served_q);
        grant_valid     = grant ? req1_valid : req0_valid;
        owner_rsp_ready = grant_id_q ? rsp1_ready : rsp0_ready;
    end

    // Next-state and datapath capture for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        grant_id_d    = grant_id_q;
        a_d           = a_q;
        b_d           = b_q;
        code_d        = code_q;
        res_d         = res_q;
        carry_d       = carry_q;
        zero_d        = zero_q;
        rsp_valid_d   = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d       = EXEC;
                    last_served_d = grant;
                    grant_id_d    = grant;
                    a_d           = grant ? req1_a    : req0_a;
                    b_d           = grant ? req1_b    : req0_b;
                    code_d        = grant ? req1_code : req0_code;
                end
            end
            EXEC: begin
                state_d                 = RESP;
                res_d                   = alu_out;
                carry_d                 = alu_carry;
                zero_d                  = alu_zero;
                rsp_valid_d[grant_id_q] = 1'b1;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 2'b00;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 2'b00;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            grant_id_q    <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            code_q        <= '0;
            res_q         <= '0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
            rsp_valid_q   <= 2'b00;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            grant_id_q    <= grant_id_d;
            a_q           <= a_d;
            b_q           <= b_d;
            code_q        <= code_d;
            res_q         <= res_d;
            carry_q       <= carry_d;
            zero_q        <= zero_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    // Output mapping; requests are only taken while idle, independent of rsp ready.
    always_comb begin
        req0_ready  = (state_q == IDLE) && !grant;
        req1_ready  = (state_q == IDLE) && grant;
        rsp0_valid  = rsp_valid_q[0];
        rsp1_valid  = rsp_valid_q[1];
        rsp0_result = res_q;
        rsp1_result = res_q;
        rsp0_carry  = carry_q;
        rsp1_carry  = carry_q;
        rsp0_zero   = zero_q;
        rsp1_zero   = zero_q;
        alu_a       = a_q;
        alu_b       = b_q;
        alu_code    = code_q;
        busy        = (state_q != IDLE);
        grant_id    = grant_id_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;
    localparam int W  = 16;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [CW-1:0] req0_code, req1_code;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]  rsp0_result, rsp1_result;
    logic          rsp0_carry, rsp0_zero, rsp1_carry, rsp1_zero;
    logic [W-1:0]  alu_a, alu_b, alu_out;
    logic [CW-1:0] alu_code;
    logic          alu_carry, alu_zero;
    logic          busy, grant_id;
    logic          alu_force;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.WIDTH(W), .CODE_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_code(req0_code),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_code(req1_code),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_carry(rsp0_carry), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_carry(rsp1_carry), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .busy(busy), .grant_id(grant_id)
    );

    // Bench ALU: returns {zero, carry, out}; force mode yields out=0, carry=1, zero=1.
    function automatic logic [17:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [CW-1:0] c, input logic frc);
        logic [16:0] r;
        if (frc) return {1'b1, 1'b1, 16'h0000};
        case (c)
            3'd0:    r = {1'b0, b};
            3'd1:    r = {1'b0, a} + {1'b0, b};
            3'd2:    r = {1'b0, a} - {1'b0, b};
            3'd3:    r = {1'b0, a & b};
            3'd4:    r = {1'b0, a | b};
            3'd5:    r = {1'b0, a ^ b};
            3'd6:    r = {a[15], a[14:0], 1'b0};
            default: r = {a[0], 1'b0, a[15:1]};
        endcase
        return {(r[15:0] == 16'h0000), r};
    endfunction

    assign {alu_zero, alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_code, alu_force);

    // Round-robin rule: a lone valid wins; on a tie the port not served last wins.
    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one pending op, age 0 while executing, 1 while awaiting pickup.
    logic          m_pend, m_age, m_owner, m_last;
    logic [W-1:0]  m_a, m_b, m_res;
    logic [CW-1:0] m_c;
    logic          m_cy, m_z;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  <= 1'b0;
            m_age   <= 1'b0;
            m_owner <= 1'b0;
            m_last  <= 1'b1;
            m_a     <= '0;
            m_b     <= '0;
            m_c     <= '0;
            m_res   <= '0;
            m_cy    <= 1'b0;
            m_z     <= 1'b0;
        end else if (!m_pend) begin
            if (pick(req0_valid, req1_valid, m_last) ? req1_valid : req0_valid) begin
                m_pend  <= 1'b1;
                m_age   <= 1'b0;
                m_owner <= pick(req0_valid, req1_valid, m_last);
                m_last  <= pick(req0_valid, req1_valid, m_last);
                m_a     <= pick(req0_valid, req1_valid, m_last) ? req1_a : req0_a;
                m_b     <= pick(req0_valid, req1_valid, m_last) ? req1_b : req0_b;
                m_c     <= pick(req0_valid, req1_valid, m_last) ? req1_code : req0_code;
            end
        end else if (!m_age) begin
            {m_z, m_cy, m_res} <= alu_fn(m_a, m_b, m_c, alu_force);
            m_age <= 1'b1;
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_pend <= 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic e0, e1, g;
        e0 = m_pend && m_age && !m_owner;
        e1 = m_pend && m_age && m_owner;
        g  = pick(req0_valid, req1_valid, m_last);
        chk("busy", 32'(busy), 32'(m_pend));
        chk("grant_id", 32'(grant_id), 32'(m_owner));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e1));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_code", 32'(alu_code), 32'(m_c));
        if (m_pend) begin
            chk("req0_ready_busy", 32'(req0_ready), 32'(0));
            chk("req1_ready_busy", 32'(req1_ready), 32'(0));
        end else begin
            if (req0_valid) chk("req0_ready", 32'(req0_ready), 32'(!g));
            if (req1_valid) chk("req1_ready", 32'(req1_ready), 32'(g));
        end
        if (e0) begin
            chk("rsp0_result", 32'(rsp0_result), 32'(m_res));
            chk("rsp0_carry", 32'(rsp0_carry), 32'(m_cy));
            chk("rsp0_zero", 32'(rsp0_zero), 32'(m_z));
        end
        if (e1) begin
            chk("rsp1_result", 32'(rsp1_result), 32'(m_res));
            chk("rsp1_carry", 32'(rsp1_carry), 32'(m_cy));
            chk("rsp1_zero", 32'(rsp1_zero), 32'(m_z));
        end
    end

    // Log of accepted requests, sampled on the DUT handshake.
    int grant_log[$];
    always @(negedge clk) begin
        if (rst_n && req0_valid && req0_ready) grant_log.push_back(0);
        if (rst_n && req1_valid && req1_ready) grant_log.push_back(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input logic port, input string name);
        int n = 0;
        @(negedge clk);
        while (!(port ? req1_ready : req0_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(port ? req1_ready : req0_ready), 32'(1));
        tick();
    endtask

    task automatic wait_rsp(input logic port, input string name);
        int n = 0;
        @(negedge clk);
        while (!(port ? rsp1_valid : rsp0_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(port ? rsp1_valid : rsp0_valid), 32'(1));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'(0));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] held;

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req0_code = '0;
        req1_a = '0; req1_b = '0; req1_code = '0;
        rsp0_ready = 0; rsp1_ready = 0;
        alu_force = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_grant_id", 32'(grant_id), 32'(0));
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'(0));
        chk("rst_alu_a", 32'(alu_a), 32'(0));
        tick();
        rst_n = 1'b1;

        // Single op: 2 + 5 on port 0.
        req0_valid = 1; req0_a = 16'h0002; req0_b = 16'h0005; req0_code = 3'b001;
        @(negedge clk);
        chk("single_req0_ready", 32'(req0_ready), 32'(1));
        tick();
        req0_valid = 0;
        @(negedge clk);
        chk("exec_alu_a", 32'(alu_a), 32'h0002);
        chk("exec_alu_b", 32'(alu_b), 32'h0005);
        chk("exec_alu_code", 32'(alu_code), 32'(3'b001));
        chk("exec_rsp0_low", 32'(rsp0_valid), 32'(0));
        tick();
        @(negedge clk);
        chk("single_rsp0_valid", 32'(rsp0_valid), 32'(1));
        chk("single_result", 32'(rsp0_result), 32'h0007);
        chk("single_carry", 32'(rsp0_carry), 32'(0));
        chk("single_zero", 32'(rsp0_zero), 32'(0));
        chk("single_rsp1_low", 32'(rsp1_valid), 32'(0));

        // Asynchronous reset while the response is pending.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp0_valid", 32'(rsp0_valid), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_alu_a", 32'(alu_a), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        req0_valid = 1; req0_a = 16'h0009; req0_b = 16'h0001; req0_code = 3'd2;
        @(negedge clk);
        chk("post_rst_req0_ready", 32'(req0_ready), 32'(1));
        tick();
        req0_valid = 0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'(1));
        rsp0_ready = 1;
        wait_idle("post_rst_done");

        // Tie from reset: grants must alternate starting with port 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        grant_log.delete();
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0000; req0_code = 3'd1;
        req1_valid = 1; req1_a = 16'h0003; req1_b = 16'h0000; req1_code = 3'd1;
        for (int i = 0; i < 100 && grant_log.size() < 8; i++) tick();
        req0_valid = 0; req1_valid = 0;
        chk("rr_count", 32'(grant_log.size() >= 8), 32'(1));
        for (int i = 0; i < 8; i++)
            if (i < grant_log.size()) chk("rr_order", 32'(grant_log[i]), 32'(i % 2));
        wait_idle("rr_done");

        // Backpressure on port 1 with port 0 waiting.
        rsp1_ready = 0; rsp0_ready = 1;
        req1_valid = 1; req1_a = 16'h1234; req1_b = 16'h0F0F; req1_code = 3'd3;
        wait_accept(1'b1, "bp_req1_accept");
        req1_valid = 0;
        req0_valid = 1; req0_a = 16'h0005; req0_b = 16'h0006; req0_code = 3'd1;
        wait_rsp(1'b1, "bp_rsp1_valid");
        held = rsp1_result;
        chk("bp_result", 32'(held), 32'h0204);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp1_valid), 32'(1));
            chk("bp_hold_result", 32'(rsp1_result), 32'(held));
            chk("bp_req0_stall", 32'(req0_ready), 32'(0));
            chk("bp_busy", 32'(busy), 32'(1));
        end
        tick();
        rsp1_ready = 1;
        @(negedge clk);
        chk("bp_released_busy", 32'(busy), 32'(1));
        tick();
        @(negedge clk);
        chk("bp_idle", 32'(busy), 32'(0));
        chk("bp_req0_ready", 32'(req0_ready), 32'(1));
        tick();
        req0_valid = 0;
        @(negedge clk);
        chk("bp_req0_taken", 32'(busy), 32'(1));
        chk("bp_req0_grant", 32'(grant_id), 32'(0));

        // Port 1 valid pulse while busy is never captured.
        tick();
        req1_valid = 1; req1_a = 16'hBEEF; req1_b = 16'h0001; req1_code = 3'd1;
        tick();
        req1_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("withdraw_no_rsp1", 32'(rsp1_valid), 32'(0));
            chk("withdraw_idle", 32'(busy), 32'(0));
        end
        tick();

        // Zero/carry path from the ALU, held under backpressure.
        alu_force = 1; rsp0_ready = 0;
        req0_valid = 1; req0_a = 16'h0007; req0_b = 16'h0009; req0_code = 3'd1;
        wait_accept(1'b0, "zc_accept");
        req0_valid = 0;
        wait_rsp(1'b0, "zc_rsp0_valid");
        for (int i = 0; i < 3; i++) begin
            chk("zc_result", 32'(rsp0_result), 32'h0000);
            chk("zc_carry", 32'(rsp0_carry), 32'(1));
            chk("zc_zero", 32'(rsp0_zero), 32'(1));
            @(negedge clk);
        end
        tick();
        rsp0_ready = 1;
        wait_idle("zc_done");
        alu_force = 0;

        // Random traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = W'($urandom); req0_b = W'($urandom); req0_code = CW'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom); req1_code = CW'($urandom);
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
            alu_force  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        alu_force = 0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
